// File: rtl/ssdma_wb_regs_if.sv
// Wishbone slave bus bundle between the PCI bridge WB master and the DMA register target.
interface ssdma_wb_regs_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_cab_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i, wbs_cab_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i, wbs_cab_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/ssdma_wb_regs.sv
// DMA control/status register target on the bridge WB master port, with a doorbell
// descriptor FIFO feeding the DMA engine and a level interrupt back to the bridge.
module ssdma_wb_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rstn_i,
  ssdma_wb_regs_if.slave wbs,
  output logic           wb_int_o,
  output logic           desc_valid_o,
  output logic [31:0]    desc_addr_o,
  input  logic           desc_ready_i,
  input  logic           done_i,
  input  logic           done_err_i,
  input  logic           engine_busy_i
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FD = 2 ** PW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = ADDR_W - 2;

  localparam logic [OW-1:0] OFF_CTRL     = OW'(0);
  localparam logic [OW-1:0] OFF_STATUS   = OW'(1);
  localparam logic [OW-1:0] OFF_DOORBELL = OW'(2);
  localparam logic [OW-1:0] OFF_DONE_CNT = OW'(3);
  localparam logic [OW-1:0] OFF_SCRATCH  = OW'(4);

  logic          ack_q, err_q, rty_q;
  logic [31:0]   dat_q;
  logic [2:0]    ctrl_q;
  logic          st_done_q, st_err_q;
  logic [15:0]   done_cnt_q;
  logic [31:0]   scratch_q;
  logic [31:0]   mem_q [FD];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          req, in_win, fifo_full, fifo_empty;
  logic [OW-1:0] off;
  logic          do_ack, do_err, do_rty;
  logic [31:0]   rdata, status_word;
  logic          wr_ack, wr_ctrl, soft_rst, w1c, push, pop;
  logic          unused_ok;

  assign unused_ok = ^{wbs.wbs_cab_i, wbs.wbs_adr_i[1:0]};

  // The registered termination masks the request, so back-to-back beats get one idle cycle.
  assign req        = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~(ack_q | err_q | rty_q);
  assign in_win     = wbs.wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W];
  assign off        = wbs.wbs_adr_i[ADDR_W-1:2];
  assign fifo_full  = count_q == CW'(DEPTH);
  assign fifo_empty = count_q == '0;

  assign status_word = {16'h0, 8'(count_q), 3'b000, engine_busy_i,
                        fifo_empty, fifo_full, st_err_q, st_done_q};

  always_comb begin
    do_ack = 1'b0;
    do_err = 1'b0;
    do_rty = 1'b0;
    rdata  = '0;
    if (req) begin
      if (!in_win) begin
        do_err = 1'b1;
      end else begin
        case (off)
          OFF_CTRL: begin
            do_ack = 1'b1;
            rdata  = {29'h0, ctrl_q};
          end
          OFF_STATUS: begin
            do_ack = 1'b1;
            rdata  = status_word;
          end
          OFF_DOORBELL: begin
            if (!wbs.wbs_we_i)                 do_ack = 1'b1;
            else if (wbs.wbs_sel_i != 4'hF)    do_err = 1'b1;
            else if (fifo_full)                do_rty = 1'b1;
            else                               do_ack = 1'b1;
          end
          OFF_DONE_CNT: begin
            if (wbs.wbs_we_i) begin
              do_err = 1'b1;
            end else begin
              do_ack = 1'b1;
              rdata  = {16'h0, done_cnt_q};
            end
          end
          OFF_SCRATCH: begin
            do_ack = 1'b1;
            rdata  = scratch_q;
          end
          default: do_err = 1'b1;
        endcase
      end
    end
  end

  assign wr_ack   = do_ack & wbs.wbs_we_i;
  assign wr_ctrl  = wr_ack & (off == OFF_CTRL);
  assign soft_rst = wr_ctrl & wbs.wbs_sel_i[3] & wbs.wbs_dat_i[31];
  assign w1c      = wr_ack & (off == OFF_STATUS) & wbs.wbs_sel_i[0];
  assign push     = wr_ack & (off == OFF_DOORBELL);
  assign pop      = desc_valid_o & desc_ready_i;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= do_ack;
      err_q <= do_err;
      rty_q <= do_rty;
      dat_q <= (do_ack & ~wbs.wbs_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ctrl_q     <= '0;
      st_done_q  <= 1'b0;
      st_err_q   <= 1'b0;
      done_cnt_q <= '0;
    end else if (soft_rst) begin
      ctrl_q     <= '0;
      st_done_q  <= 1'b0;
      st_err_q   <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (wr_ctrl && wbs.wbs_sel_i[0]) ctrl_q <= wbs.wbs_dat_i[2:0];
      // A completion arriving with a W1C of the same bit keeps the bit set.
      st_done_q <= (st_done_q & ~(w1c & wbs.wbs_dat_i[0])) | done_i;
      st_err_q  <= (st_err_q  & ~(w1c & wbs.wbs_dat_i[1])) | (done_i & done_err_i);
      if (done_i) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      scratch_q <= '0;
    end else if (wr_ack && off == OFF_SCRATCH) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs.wbs_sel_i[b]) scratch_q[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FD; i++) mem_q[i] <= '0;
    end else if (soft_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wbs.wbs_dat_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;
  assign wbs.wbs_rty_o = rty_q;
  assign wbs.wbs_dat_o = dat_q;

  assign desc_valid_o = ~fifo_empty & ctrl_q[0];
  assign desc_addr_o  = mem_q[rd_ptr_q];
  assign wb_int_o     = (st_done_q & ctrl_q[1]) | (st_err_q & ctrl_q[2]);
endmodule

// File: tb/tb_ssdma_wb_regs.sv
// Directed plus randomized bench for ssdma_wb_regs against a transaction-level register/queue model.
module tb_ssdma_wb_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_o, desc_valid, desc_ready = 1'b0;
  logic [31:0] desc_addr;
  logic        done = 1'b0, done_err = 1'b0, eng_busy = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  ssdma_wb_regs_if bus_if();

  ssdma_wb_regs #(.BASE_ADDR(32'h0), .ADDR_W(8), .DEPTH(4)) dut (
    .wb_clk_i      (clk),
    .wb_rstn_i     (rst_n),
    .wbs           (bus_if),
    .wb_int_o      (int_o),
    .desc_valid_o  (desc_valid),
    .desc_addr_o   (desc_addr),
    .desc_ready_i  (desc_ready),
    .done_i        (done),
    .done_err_i    (done_err),
    .engine_busy_i (eng_busy)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [2:0]  m_ctrl;
  logic        m_done, m_err;
  logic [15:0] m_cnt;
  logic [31:0] m_scratch;
  logic [31:0] m_q[$];

  task automatic model_reset();
    m_ctrl = '0; m_done = 0; m_err = 0; m_cnt = '0; m_scratch = '0;
    m_q.delete();
  endtask

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(m_q.size()), 3'b000, eng_busy, m_q.size() == 0, m_q.size() == 4, m_err, m_done};
  endfunction

  function automatic logic m_valid();
    return m_ctrl[0] && m_q.size() > 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Terminations are one-hot {ack,err,rty}.
  task automatic model_access(input logic [31:0] a, d, input logic [3:0] s, input logic w,
                              input logic dn, de, rdy,
                              output logic [2:0] et, output logic [31:0] ed);
    logic [7:0] boff;
    logic       full, v0, srst;
    boff = a[7:0] & 8'hFC;
    full = m_q.size() == 4;
    v0   = m_valid();
    srst = 0;
    et   = 3'b010;
    ed   = '0;
    if (a[31:8] == 24'h0) begin
      case (boff)
        8'h00: begin et = 3'b100; ed = w ? 32'h0 : {29'h0, m_ctrl}; end
        8'h04: begin et = 3'b100; ed = w ? 32'h0 : m_status(); end
        8'h08: if (!w) et = 3'b100; else if (s != 4'hF) et = 3'b010;
               else if (full) et = 3'b001; else et = 3'b100;
        8'h0C: if (!w) begin et = 3'b100; ed = {16'h0, m_cnt}; end
        8'h10: begin et = 3'b100; ed = w ? 32'h0 : m_scratch; end
        default: et = 3'b010;
      endcase
    end
    if (v0 && rdy) void'(m_q.pop_front());
    if (et == 3'b100 && w) begin
      case (boff)
        8'h00: if (s[3] && d[31]) begin
                 srst = 1; m_ctrl = '0; m_q.delete(); m_done = 0; m_err = 0; m_cnt = '0;
               end else if (s[0]) m_ctrl = d[2:0];
        8'h04: if (s[0]) begin
                 if (d[0]) m_done = 0;
                 if (d[1]) m_err = 0;
               end
        8'h08: m_q.push_back(d);
        8'h10: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
        default: ;
      endcase
    end
    if (dn && !srst) begin
      m_done = 1;
      m_cnt  = m_cnt + 16'd1;
      if (de) m_err = 1;
    end
  endtask

  task automatic bus(input string tag, input logic [31:0] a, d, input logic [3:0] s,
                     input logic w, input logic dn, de, rdy);
    logic [2:0]  et;
    logic [31:0] ed;
    @(posedge clk); #1;
    model_access(a, d, s, w, dn, de, rdy, et, ed);
    bus_if.wbs_adr_i = a; bus_if.wbs_dat_i = d; bus_if.wbs_sel_i = s; bus_if.wbs_we_i = w;
    bus_if.wbs_cyc_i = 1; bus_if.wbs_stb_i = 1;
    done = dn; done_err = de; desc_ready = rdy;
    @(posedge clk); #1;
    bus_if.wbs_cyc_i = 0; bus_if.wbs_stb_i = 0; bus_if.wbs_we_i = 0;
    done = 0; done_err = 0; desc_ready = 0;
    chk({tag, ".term"}, {bus_if.wbs_ack_o, bus_if.wbs_err_o, bus_if.wbs_rty_o}, et);
    chk({tag, ".dat"}, bus_if.wbs_dat_o, ed);
    chk({tag, ".int"}, int_o, (m_done & m_ctrl[1]) | (m_err & m_ctrl[2]));
    chk({tag, ".valid"}, desc_valid, m_valid());
    if (m_valid()) chk({tag, ".head"}, desc_addr, m_q[0]);
  endtask

  task automatic pop_run(input int n);
    for (int i = 0; i < n; i++) begin
      desc_ready = 1'b1;
      #4;
      chk("pop.valid", desc_valid, m_valid());
      if (m_valid()) begin
        chk("pop.addr", desc_addr, m_q[0]);
        void'(m_q.pop_front());
      end
      @(posedge clk); #1;
    end
    desc_ready = 1'b0;
  endtask

  task automatic pulse_done(input logic de);
    @(posedge clk); #1;
    done = 1; done_err = de;
    @(posedge clk); #1;
    done = 0; done_err = 0;
    m_done = 1; m_cnt = m_cnt + 16'd1;
    if (de) m_err = 1;
    chk("done.int", int_o, (m_done & m_ctrl[1]) | (m_err & m_ctrl[2]));
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        w;
    bus_if.wbs_adr_i = '0; bus_if.wbs_dat_i = '0; bus_if.wbs_sel_i = '0;
    bus_if.wbs_we_i = 0; bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0; bus_if.wbs_cab_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.term", {bus_if.wbs_ack_o, bus_if.wbs_err_o, bus_if.wbs_rty_o}, 3'b000);
    chk("rst.dat", bus_if.wbs_dat_o, 32'h0);
    chk("rst.int", int_o, 1'b0);
    chk("rst.valid", desc_valid, 1'b0);
    chk("rst.addr", desc_addr, 32'h0);
    rst_n = 1;

    bus("rd_status0", 32'h04, 0, 4'hF, 0, 0, 0, 0);
    bus("rd_scratch0", 32'h10, 0, 4'hF, 0, 0, 0, 0);
    bus("rd_ctrl0", 32'h00, 0, 4'hF, 0, 0, 0, 0);

    bus("wr_scratch", 32'h10, 32'hDEADBEEF, 4'b0011, 1, 0, 0, 0);
    bus("rd_scratch", 32'h10, 0, 4'hF, 0, 0, 0, 0);
    bus("rd_0x20", 32'h20, 0, 4'hF, 0, 0, 0, 0);
    bus("rd_0x14", 32'h14, 0, 4'hF, 0, 0, 0, 0);
    bus("rd_outwin", 32'h0000_0110, 0, 4'hF, 0, 0, 0, 0);
    bus("wr_outwin", 32'h8000_0010, 32'h1234, 4'hF, 1, 0, 0, 0);
    bus("wr_cnt_ro", 32'h0C, 32'h5, 4'hF, 1, 0, 0, 0);
    bus("db_partial", 32'h08, 32'h77, 4'h7, 1, 0, 0, 0);
    bus("rd_db", 32'h08, 0, 4'hF, 0, 0, 0, 0);
    bus("rd_scratch2", 32'h10, 0, 4'hF, 0, 0, 0, 0);

    bus("ctrl_en", 32'h00, 32'h1, 4'hF, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) bus("db_fill", 32'h08, 32'h1000 + i, 4'hF, 1, 0, 0, 0);
    bus("rd_status_full", 32'h04, 0, 4'hF, 0, 0, 0, 0);
    bus("db_full_pop", 32'h08, 32'h1005, 4'hF, 1, 0, 0, 1);
    bus("db_refill", 32'h08, 32'h1006, 4'hF, 1, 0, 0, 0);
    pop_run(5);
    bus("rd_status_empty", 32'h04, 0, 4'hF, 0, 0, 0, 0);

    bus("ctrl_7", 32'h00, 32'h7, 4'hF, 1, 0, 0, 0);
    pulse_done(1);
    bus("rd_cnt1", 32'h0C, 0, 4'hF, 0, 0, 0, 0);
    bus("w1c_race", 32'h04, 32'h3, 4'hF, 1, 1, 0, 0);
    bus("rd_status_race", 32'h04, 0, 4'hF, 0, 0, 0, 0);
    bus("rd_cnt2", 32'h0C, 0, 4'hF, 0, 0, 0, 0);
    bus("w1c_nosel0", 32'h04, 32'h3, 4'hE, 1, 0, 0, 0);
    bus("w1c_clear", 32'h04, 32'h3, 4'h1, 1, 0, 0, 0);

    eng_busy = 1;
    bus("rd_status_busy", 32'h04, 0, 4'hF, 0, 0, 0, 0);
    eng_busy = 0;

    bus("ctrl_dis", 32'h00, 32'h0, 4'hF, 1, 0, 0, 0);
    bus("db_dis", 32'h08, 32'h2000, 4'hF, 1, 0, 0, 0);
    pop_run(2);
    bus("ctrl_en2", 32'h00, 32'h1, 4'h1, 1, 0, 0, 0);
    pop_run(2);

    for (int i = 0; i < 80; i++) begin
      a = {24'h0, 3'b000, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a[12] = 1'b1;
      d = $urandom;
      s = 4'($urandom);
      w = 1'($urandom_range(0, 1));
      if (a[7:2] == 6'd0 && $urandom_range(0, 7) != 0) d[31] = 1'b0;
      if (a[7:2] == 6'd2 && $urandom_range(0, 3) != 0) begin s = 4'hF; w = 1'b1; end
      eng_busy = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        4: pop_run($urandom_range(1, 3));
        5: pulse_done(1'($urandom_range(0, 1)));
        default: bus("rnd", a, d, s, w, $urandom_range(0, 3) == 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end
    eng_busy = 0;

    bus("sr_scr", 32'h10, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 0);
    bus("sr_ctrl", 32'h00, 32'h3, 4'hF, 1, 0, 0, 0);
    pulse_done(0);
    bus("sr_db1", 32'h08, 32'h3000, 4'hF, 1, 0, 0, 0);
    bus("sr_db2", 32'h08, 32'h3001, 4'hF, 1, 0, 0, 0);
    bus("soft_rst", 32'h00, 32'h8000_0001, 4'hF, 1, 0, 0, 0);
    bus("sr_status", 32'h04, 0, 4'hF, 0, 0, 0, 0);
    bus("sr_ctrl_rd", 32'h00, 0, 4'hF, 0, 0, 0, 0);
    bus("sr_cnt", 32'h0C, 0, 4'hF, 0, 0, 0, 0);
    bus("sr_scratch", 32'h10, 0, 4'hF, 0, 0, 0, 0);

    // Strobe held across the termination: one idle cycle, then a second beat.
    @(posedge clk); #1;
    bus_if.wbs_adr_i = 32'h10; bus_if.wbs_we_i = 0; bus_if.wbs_sel_i = 4'hF;
    bus_if.wbs_cyc_i = 1; bus_if.wbs_stb_i = 1; bus_if.wbs_cab_i = 1;
    @(posedge clk); #1;
    chk("hold.ack1", {bus_if.wbs_ack_o, bus_if.wbs_err_o, bus_if.wbs_rty_o}, 3'b100);
    chk("hold.dat1", bus_if.wbs_dat_o, m_scratch);
    @(posedge clk); #1;
    chk("hold.gap", {bus_if.wbs_ack_o, bus_if.wbs_err_o, bus_if.wbs_rty_o}, 3'b000);
    chk("hold.gapdat", bus_if.wbs_dat_o, 32'h0);
    @(posedge clk); #1;
    chk("hold.ack2", {bus_if.wbs_ack_o, bus_if.wbs_err_o, bus_if.wbs_rty_o}, 3'b100);
    bus_if.wbs_cyc_i = 0; bus_if.wbs_stb_i = 0; bus_if.wbs_cab_i = 0;

    bus("mr_ctrl", 32'h00, 32'h3, 4'hF, 1, 0, 0, 0);
    pulse_done(0);
    bus("mr_db", 32'h08, 32'h4000, 4'hF, 1, 0, 0, 0);
    @(posedge clk); #1;
    bus_if.wbs_adr_i = 32'h04; bus_if.wbs_we_i = 0; bus_if.wbs_cyc_i = 1; bus_if.wbs_stb_i = 1;
    @(posedge clk); #1;
    chk("mr.ack", {bus_if.wbs_ack_o, bus_if.wbs_err_o, bus_if.wbs_rty_o}, 3'b100);
    rst_n = 0;
    #1;
    chk("mr.term", {bus_if.wbs_ack_o, bus_if.wbs_err_o, bus_if.wbs_rty_o}, 3'b000);
    chk("mr.dat", bus_if.wbs_dat_o, 32'h0);
    chk("mr.int", int_o, 1'b0);
    chk("mr.valid", desc_valid, 1'b0);
    bus_if.wbs_cyc_i = 0; bus_if.wbs_stb_i = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    bus("post_rst_status", 32'h04, 0, 4'hF, 0, 0, 0, 0);
    bus("post_rst_scratch", 32'h10, 0, 4'hF, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
